// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

    typedef logic [31:0] bus32_t;

    // Canonical RISC-V NOP (addi x0, x0, 0), shown on the pop side when empty.
    localparam bus32_t NOP_INSTR_HEX = 32'h0000_0013;

    // One queued fetch: program counter, instruction word and kanata trace id.
    typedef struct packed {
        bus32_t pc;
        bus32_t instr;
        int     kanata_id;
    } fetch_entry_t;

    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    typedef logic [$clog2(FETCH_QUEUE_DEPTH):0] fetch_queue_cnt_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Push (fetch) and pop (decode) handshake bundle of the fetch queue.
// Signal suffixes are from the queue's point of view.
interface fetch_queue_if;

    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_pc_i;
    logic [31:0] push_instr_i;
    logic [31:0] push_kanata_id_i;

    logic        pop_valid_o;
    logic        pop_ready_i;
    logic [31:0] pop_pc_o;
    logic [31:0] pop_instr_o;
    logic [31:0] pop_kanata_id_o;

    // Queue side.
    modport slave (
        input  push_valid_i, push_pc_i, push_instr_i, push_kanata_id_i, pop_ready_i,
        output push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, pop_kanata_id_o
    );

    // Fetch/decode side.
    modport master (
        output push_valid_i, push_pc_i, push_instr_i, push_kanata_id_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, pop_kanata_id_o
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and the decode latch.
// Show-ahead head, no same-cycle bypass, single-cycle flush on commit redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    fetch_queue_if.slave     fq,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push_fire;
    logic pop_fire;
    fetch_entry_t head;

    // Handshake status and show-ahead head, from registered state only.
    always_comb begin
        full            = (count_q == CNT_W'(DEPTH));
        empty           = (count_q == '0);
        fq.push_ready_o = !full && !rst_i;
        fq.pop_valid_o  = !empty;
        push_fire       = fq.push_valid_i && fq.push_ready_o;
        pop_fire        = fq.pop_valid_o && fq.pop_ready_i;
        head            = mem_q[rd_ptr_q];
        if (empty) begin
            fq.pop_pc_o        = '0;
            fq.pop_instr_o     = NOP_INSTR_HEX;
            fq.pop_kanata_id_o = '0;
        end else begin
            fq.pop_pc_o        = head.pc;
            fq.pop_instr_o     = head.instr;
            fq.pop_kanata_id_o = head.kanata_id;
        end
        count_o = count_q;
    end

    // Next pointers, occupancy and storage; flush discards any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) begin
                mem_d[wr_ptr_q] = '{pc:        fq.push_pc_i,
                                    instr:     fq.push_instr_i,
                                    kanata_id: int'(fq.push_kanata_id_i)};
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset overrides flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is not reset; empty masking hides stale contents.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule
